// File: rtl/cachemem_2way.sv
// Two-way set-associative cache array: valid/tag/data per way, per-set LRU bit, combinational tag compare.
// Zero-latency read and victim select; fills, invalidates and flush commit at the rising edge.
module cachemem_2way #(
  parameter int DATA_SIZE = 64,
  parameter int IDX_BITS  = 5,
  parameter int TAG_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd1_en,
  input  logic [IDX_BITS-1:0]  rd1_idx,
  input  logic [TAG_BITS-1:0]  rd1_tag,
  output logic [DATA_SIZE-1:0] rd1_data,
  output logic                 rd1_valid,
  output logic                 rd1_way,
  input  logic                 wr1_en,
  input  logic [IDX_BITS-1:0]  wr1_idx,
  input  logic [TAG_BITS-1:0]  wr1_tag,
  input  logic [DATA_SIZE-1:0] wr1_data,
  output logic                 wr1_victim_way,
  output logic                 wr1_victim_valid,
  input  logic                 inv_en,
  input  logic [IDX_BITS-1:0]  inv_idx,
  input  logic [TAG_BITS-1:0]  inv_tag,
  input  logic                 flush
);
  localparam int SETS = 2 ** IDX_BITS;

  logic [1:0]           r_valid [SETS];
  logic [TAG_BITS-1:0]  r_tag   [SETS][2];
  logic [DATA_SIZE-1:0] r_data  [SETS][2];
  logic [SETS-1:0]      r_lru;

  logic [1:0] w_rd_hit;
  logic [1:0] w_wr_match;
  logic [1:0] w_inv_hit;
  logic       w_vict;
  logic       w_inv_way;

  always_comb begin
    w_rd_hit   = 2'b00;
    w_wr_match = 2'b00;
    w_inv_hit  = 2'b00;
    for (int w = 0; w < 2; w++) begin
      w_rd_hit[w]   = r_valid[rd1_idx][w] && (r_tag[rd1_idx][w] == rd1_tag);
      w_wr_match[w] = r_valid[wr1_idx][w] && (r_tag[wr1_idx][w] == wr1_tag);
      w_inv_hit[w]  = r_valid[inv_idx][w] && (r_tag[inv_idx][w] == inv_tag);
    end
  end

  // Way 0 wins a double match; fills never create one.
  assign rd1_valid = |w_rd_hit;
  assign rd1_way   = ~w_rd_hit[0] & w_rd_hit[1];
  assign rd1_data  = r_data[rd1_idx][rd1_way];

  always_comb begin
    w_vict = r_lru[wr1_idx];
    if (w_wr_match[0])               w_vict = 1'b0;
    else if (w_wr_match[1])          w_vict = 1'b1;
    else if (!r_valid[wr1_idx][0])   w_vict = 1'b0;
    else if (!r_valid[wr1_idx][1])   w_vict = 1'b1;
  end

  assign wr1_victim_way   = w_vict;
  assign wr1_victim_valid = r_valid[wr1_idx][w_vict] && (r_tag[wr1_idx][w_vict] != wr1_tag);
  assign w_inv_way        = ~w_inv_hit[0];

  // Later assignments win: read LRU < invalidate < fill.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= 2'b00;
      r_lru <= '0;
    end else begin
      if (rd1_en && rd1_valid) r_lru[rd1_idx] <= ~rd1_way;
      if (inv_en && (|w_inv_hit)) begin
        r_valid[inv_idx][w_inv_way] <= 1'b0;
        r_lru[inv_idx]              <= w_inv_way;
      end
      if (wr1_en) begin
        r_valid[wr1_idx][w_vict] <= 1'b1;
        r_lru[wr1_idx]           <= ~w_vict;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush && wr1_en) begin
      r_tag[wr1_idx][w_vict]  <= wr1_tag;
      r_data[wr1_idx][w_vict] <= wr1_data;
    end
  end
endmodule

// File: tb/tb_cachemem_2way.sv
// Bench for cachemem_2way: directed test-plan steps then random traffic, against a per-set reference model.
module tb_cachemem_2way;
  localparam int DW = 64, IW = 5, TW = 8, SETS = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd1_en;
  logic [IW-1:0] rd1_idx;
  logic [TW-1:0] rd1_tag;
  logic [DW-1:0] rd1_data;
  logic          rd1_valid, rd1_way;
  logic          wr1_en;
  logic [IW-1:0] wr1_idx;
  logic [TW-1:0] wr1_tag;
  logic [DW-1:0] wr1_data;
  logic          wr1_victim_way, wr1_victim_valid;
  logic          inv_en;
  logic [IW-1:0] inv_idx;
  logic [TW-1:0] inv_tag;
  logic          flush;

  cachemem_2way #(.DATA_SIZE(DW), .IDX_BITS(IW), .TAG_BITS(TW)) dut (
    .clock(clock), .reset(reset),
    .rd1_en(rd1_en), .rd1_idx(rd1_idx), .rd1_tag(rd1_tag),
    .rd1_data(rd1_data), .rd1_valid(rd1_valid), .rd1_way(rd1_way),
    .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data),
    .wr1_victim_way(wr1_victim_way), .wr1_victim_valid(wr1_victim_valid),
    .inv_en(inv_en), .inv_idx(inv_idx), .inv_tag(inv_tag), .flush(flush)
  );

  always #5 clock = ~clock;

  // Reference model: each set is two lines plus the index of the next victim.
  logic          m_v   [SETS][2];
  logic [TW-1:0] m_t   [SETS][2];
  logic [DW-1:0] m_d   [SETS][2];
  logic          m_lru [SETS];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                   output logic hit, output logic way);
    hit = 1'b0;
    way = 1'b0;
    for (int w = 1; w >= 0; w--)
      if (m_v[idx][w] && m_t[idx][w] == tag) begin
        hit = 1'b1;
        way = w[0];
      end
  endfunction

  function automatic void m_victim(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                                   output logic way, output logic evict);
    logic hit;
    m_lookup(idx, tag, hit, way);
    if (!hit) begin
      if (!m_v[idx][0])      way = 1'b0;
      else if (!m_v[idx][1]) way = 1'b1;
      else                   way = m_lru[idx];
    end
    evict = m_v[idx][way] && (m_t[idx][way] != tag);
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_v[s][0] = 1'b0;
      m_v[s][1] = 1'b0;
      m_lru[s]  = 1'b0;
    end
  endfunction

  task automatic idle();
    reset = 1'b0; flush = 1'b0;
    rd1_en = 1'b0; rd1_idx = '0; rd1_tag = '0;
    wr1_en = 1'b0; wr1_idx = '0; wr1_tag = '0; wr1_data = '0;
    inv_en = 1'b0; inv_idx = '0; inv_tag = '0;
  endtask

  // Check combinational outputs against the model, advance the model, then take the edge.
  task automatic cycle();
    logic rh, rw, vw, vv, ih, iw;
    #2;
    m_lookup(rd1_idx, rd1_tag, rh, rw);
    check("rd1_valid", rd1_valid, rh);
    check("rd1_way", rd1_way, rw);
    if (rh) check("rd1_data", rd1_data, m_d[rd1_idx][rw]);
    m_victim(wr1_idx, wr1_tag, vw, vv);
    check("victim_way", wr1_victim_way, vw);
    check("victim_valid", wr1_victim_valid, vv);
    m_lookup(inv_idx, inv_tag, ih, iw);
    if (reset || flush) begin
      m_clear();
    end else begin
      if (rd1_en && rh) m_lru[rd1_idx] = ~rw;
      if (inv_en && ih) begin
        m_v[inv_idx][iw] = 1'b0;
        m_lru[inv_idx]   = iw;
      end
      if (wr1_en) begin
        m_v[wr1_idx][vw] = 1'b1;
        m_t[wr1_idx][vw] = wr1_tag;
        m_d[wr1_idx][vw] = wr1_data;
        m_lru[wr1_idx]   = ~vw;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [DW-1:0] d);
    idle();
    wr1_en = 1'b1; wr1_idx = idx; wr1_tag = tag; wr1_data = d;
    cycle();
  endtask

  task automatic read(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
    idle();
    rd1_en = 1'b1; rd1_idx = idx; rd1_tag = tag;
    cycle();
  endtask

  localparam logic [DW-1:0] DATA_A = 64'hA5A5_0000_1111_2222;
  localparam logic [DW-1:0] DATA_B = 64'hB0B0_3333_4444_5555;

  initial begin
    for (int s = 0; s < SETS; s++) begin
      m_t[s][0] = '0; m_t[s][1] = '0; m_d[s][0] = '0; m_d[s][1] = '0;
    end
    m_clear();
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    idle();

    // Post-reset: everything misses, victim is way 0 with no eviction.
    rd1_en = 1'b1; rd1_idx = 5'd3; rd1_tag = 8'h12;
    wr1_idx = 5'd9; wr1_tag = 8'h77;
    #1;
    check("rst_rd_valid", rd1_valid, 1'b0);
    check("rst_victim_way", wr1_victim_way, 1'b0);
    check("rst_victim_valid", wr1_victim_valid, 1'b0);
    cycle();

    fill(5'd3, 8'h12, DATA_A);
    idle();
    rd1_en = 1'b1; rd1_idx = 5'd3; rd1_tag = 8'h12;
    #1;
    check("fill_hit", rd1_valid, 1'b1);
    check("fill_way", rd1_way, 1'b0);
    check("fill_data", rd1_data, DATA_A);
    cycle();

    // LRU victim selection after a read hit.
    fill(5'd3, 8'h34, 64'h34);
    read(5'd3, 8'h12);
    idle();
    wr1_en = 1'b1; wr1_idx = 5'd3; wr1_tag = 8'h56; wr1_data = 64'h56;
    #1;
    check("lru_victim_way", wr1_victim_way, 1'b1);
    check("lru_victim_valid", wr1_victim_valid, 1'b1);
    cycle();
    read(5'd3, 8'h34);
    read(5'd3, 8'h12);
    read(5'd3, 8'h56);

    // Refresh in place, then invalidate and refill the freed way.
    fill(5'd3, 8'h12, DATA_B);
    read(5'd3, 8'h12);
    read(5'd3, 8'h56);
    idle(); inv_en = 1'b1; inv_idx = 5'd3; inv_tag = 8'h12; cycle();
    read(5'd3, 8'h12);
    idle(); inv_en = 1'b1; inv_idx = 5'd3; inv_tag = 8'h99; cycle();
    fill(5'd3, 8'h78, 64'h78);
    read(5'd3, 8'h78);

    // Flush with a concurrent fill.
    fill(5'd1, 8'h01, 64'h1);
    fill(5'd2, 8'h02, 64'h2);
    idle(); flush = 1'b1; wr1_en = 1'b1; wr1_idx = 5'd4; wr1_tag = 8'h04; wr1_data = 64'h4; cycle();
    for (int s = 1; s <= 4; s++) begin
      idle();
      rd1_en = 1'b1; rd1_idx = s[IW-1:0]; rd1_tag = s[TW-1:0];
      wr1_idx = s[IW-1:0]; wr1_tag = 8'hEE;
      cycle();
    end

    // Same-cycle fill+read, then same-cycle fill+invalidate.
    idle();
    wr1_en = 1'b1; wr1_idx = 5'd5; wr1_tag = 8'h07; wr1_data = 64'h7;
    rd1_en = 1'b1; rd1_idx = 5'd5; rd1_tag = 8'h07;
    cycle();
    read(5'd5, 8'h07);
    idle();
    wr1_en = 1'b1; wr1_idx = 5'd5; wr1_tag = 8'h07; wr1_data = 64'h17;
    inv_en = 1'b1; inv_idx = 5'd5; inv_tag = 8'h07;
    cycle();
    read(5'd5, 8'h07);

    // Random traffic over a few sets and tags to force conflicts.
    for (int i = 0; i < 600; i++) begin
      idle();
      reset    = ($urandom_range(99, 0) == 0);
      flush    = ($urandom_range(49, 0) == 0);
      rd1_en   = $urandom_range(1, 0);
      rd1_idx  = 5'($urandom_range(3, 0));
      rd1_tag  = 8'($urandom_range(3, 0));
      wr1_en   = $urandom_range(1, 0);
      wr1_idx  = 5'($urandom_range(3, 0));
      wr1_tag  = 8'($urandom_range(3, 0));
      wr1_data = {$urandom, $urandom};
      inv_en   = ($urandom_range(3, 0) == 0);
      inv_idx  = 5'($urandom_range(3, 0));
      inv_tag  = 8'($urandom_range(3, 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
